// File: rtl/ao_reduce_pipe.sv
`default_nettype none
// ============================================================================
// ao_reduce_pipe: two-stage pipelined AND-OR / OR-AND reduction of P operand
// pairs with valid/ready handshakes and a completed-transaction counter.
// Revision: 1.0
// ============================================================================
module ao_reduce_pipe #(
  parameter int W     = 4,
  parameter int P     = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P*W-1:0]     in_a,
  input  logic [P*W-1:0]     in_b,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_y,
  output logic [CNT_W-1:0]   out_cnt
);

  // Mode bit 0 selects OR-first terms (OA/OAI); mode bit 1 inverts the result.
  localparam int c_OR_TERM_BIT = 0;
  localparam int c_INV_BIT     = 1;

  logic               r_s1_valid;
  logic [P*W-1:0]     r_s1_terms;
  logic [1:0]         r_s1_mode;
  logic               r_out_valid;
  logic [W-1:0]       r_out_y;
  logic [CNT_W-1:0]   r_cnt;

  logic [P*W-1:0]     w_terms;
  logic [W-1:0]       w_reduce;
  logic [W-1:0]       w_result;
  logic               w_s2_free;
  logic               w_s1_adv;
  logic               w_in_acc;
  logic               w_out_xfer;

  assign w_s2_free  = ~r_out_valid | out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_free;
  assign in_ready   = ~r_s1_valid | w_s2_free;
  assign w_in_acc   = in_valid & in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_term
      assign w_terms[gi*W +: W] = in_mode[c_OR_TERM_BIT]
                                ? (in_a[gi*W +: W] | in_b[gi*W +: W])
                                : (in_a[gi*W +: W] & in_b[gi*W +: W]);
    end
  endgenerate

  // Identity element of the reduction: all-ones for AND, all-zeros for OR.
  always_comb begin
    w_reduce = r_s1_mode[c_OR_TERM_BIT] ? {W{1'b1}} : {W{1'b0}};
    for (int i = 0; i < P; i++) begin
      if (r_s1_mode[c_OR_TERM_BIT]) begin
        w_reduce = w_reduce & r_s1_terms[i*W +: W];
      end else begin
        w_reduce = w_reduce | r_s1_terms[i*W +: W];
      end
    end
    w_result = r_s1_mode[c_INV_BIT] ? ~w_reduce : w_reduce;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_terms <= '0;
      r_s1_mode  <= 2'b00;
    end else if (w_in_acc) begin
      r_s1_valid <= 1'b1;
      r_s1_terms <= w_terms;
      r_s1_mode  <= in_mode;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_y     <= w_result;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_out_xfer) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: doc/ao_reduce_pipe.md
Name: ao_reduce_pipe

Overview:
Parametrised, pipelined successor to the team's combinational AND-OR (ao) cells.
- Reduces P operand pairs of W bits each to one W-bit result.
- Four selectable logic modes: AND-OR, OR-AND, and their inverted forms.
- Two register stages: stage 1 holds the per-pair terms, stage 2 holds the reduced result.
- valid/ready handshake on input and output for use inside streaming datapaths, plus a completed-transaction counter.

Parameters:
W, 4, bit width of each operand and of the result
P, 2, number of operand pairs (P >= 1)
CNT_W, 8, width of the completed-transaction counter

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block accepts input this cycle
in_a  input  P*W  operands a_i, pair i at bits [i*W +: W]
in_b  input  P*W  operands b_i, same packing
in_mode  input  2  0=AO, 1=OA, 2=AOI, 3=OAI; sampled with the input beat
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
out_y  output  W  result
out_cnt  output  CNT_W  number of completed output handshakes

Behaviour:
- One clock, clk. Reset is synchronous and active-high: reset sampled high at a clk rising edge clears all state.
- Reset values: out_valid=0, out_y=0, out_cnt=0, and stage-1 valid, terms and mode cleared. in_ready reads 1 in the first cycle after reset.
- Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Stage 1, loaded on input accept:
  - modes 0 and 2: t_i = a_i & b_i
  - modes 1 and 3: t_i = a_i | b_i
  - in_mode is stored alongside the terms.
- Stage 2, loaded when stage 1 advances:
  - modes 0 and 2: r = OR over i of t_i
  - modes 1 and 3: r = AND over i of t_i
  - modes 2 and 3: r is bitwise inverted.
  - All operations are bitwise and W wide. There is no carry or width growth.
- Advance rules:
  - s2_free = ~out_valid | out_ready
  - stage 1 advances when s1_valid & s2_free
  - in_ready = ~s1_valid | s2_free (combinational from out_ready; no combinational path from in_valid to in_ready)
- Latency: an accepted beat appears on out_valid/out_y 2 cycles after acceptance when no backpressure is applied.
- Throughput: one beat per cycle with out_ready held high.
- Backpressure:
  - While out_valid & ~out_ready, out_y and out_valid hold stable.
  - Stage 1 holds if it is full.
  - At most 2 beats are buffered; in_ready=0 when both stages are full and out_ready=0.
- Simultaneous events: output transfer and stage-1 advance in the same cycle replace stage 2 with no bubble. Input accept and stage-1 advance in the same cycle replace stage 1.
- Ordering: strict in-order, with no drop and no duplication.
- out_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: all in-flight beats are discarded with no output transfer, out_cnt is cleared, and a beat offered in the reset cycle is not accepted.
- P=1 degenerates to a registered a&b, a|b, or their inverses, still with 2-cycle latency.

Test Plan:
1. P=2, W=4, mode 0, a0=1100 b0=1010 a1=0011 b1=0110, out_ready=1 -> out_valid 2 cycles after accept, out_y=1010, out_cnt=1.
2. Same operands, modes 1, 2 and 3 sent back-to-back -> out_y=0110, 0101, 1001 on 3 consecutive cycles; out_cnt=3.
3. out_ready=0, in_valid=1 with 4 distinct beats -> 2 beats accepted, then in_ready=0; out_y holds beat 1. Raise out_ready -> beats 1-4 appear in order, one per cycle; out_cnt=4.
4. Alternate out_ready 1/0 every cycle under continuous input -> no loss or duplication; results match a reference model; out_y stable during stalls.
5. CNT_W=2, 5 output transfers -> out_cnt sequence 1,2,3,0,1.
6. Assert reset for 1 cycle with both stages full and out_ready=0 -> next cycle out_valid=0, out_cnt=0, in_ready=1, and no stale beat appears afterwards.
